pipe_skid_stage: RTL

- Parametrised, elastic successor to the fixed IF/ID pipeline register.
- Carries a PC plus instruction word between any two pipeline stages using a valid/ready handshake.
- Holds a 2-entry skid buffer so the upstream stage sees a registered ready, and supports a synchronous flush that inserts a bubble.
- Used first between fetch and decode; reusable at later stage boundaries.

---
 rtl/pipe_skid_stage.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/pipe_skid_stage.sv
// Elastic two-entry pipeline stage carrying PC + instruction with a registered in_ready.
// Optional performance counters are built when PERF_CNT_EN is defined.
module pipe_skid_stage #(
  parameter int unsigned      PC_W     = 64,
  parameter int unsigned      INST_W   = 32,
  parameter logic [INST_W-1:0] NOP_INST = 32'h00000013,
  parameter int unsigned      CNT_W    = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PC_W-1:0]   in_pc,
  input  logic [INST_W-1:0] in_inst,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PC_W-1:0]   out_pc,
  output logic [INST_W-1:0] out_inst,
  input  logic              flush
`ifdef PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]  stall_cycles,
  output logic [CNT_W-1:0]  flush_kills
`endif
);

  if (CNT_W == 0) begin : g_cnt_w_check
    $error("CNT_W must be nonzero");
  end

  typedef enum logic [1:0] {StEmpty, StBusy, StFull} state_e;

  state_e              state_q, state_d;
  logic [PC_W-1:0]     main_pc_q, main_pc_d;
  logic [INST_W-1:0]   main_inst_q, main_inst_d;
  logic [PC_W-1:0]     skid_pc_q, skid_pc_d;
  logic [INST_W-1:0]   skid_inst_q, skid_inst_d;

  logic main_valid, skid_valid, acc_in, acc_out;

  assign main_valid = (state_q != StEmpty);
  assign skid_valid = (state_q == StFull);
  assign in_ready   = ~skid_valid;
  assign out_valid  = main_valid;
  assign out_pc     = main_pc_q;
  assign out_inst   = main_inst_q;
  assign acc_in     = in_valid & in_ready;
  assign acc_out    = main_valid & out_ready;

  // Main register is forced to NOP/0 whenever it goes empty so outputs need no masking.
  always_comb begin
    state_d     = state_q;
    main_pc_d   = main_pc_q;
    main_inst_d = main_inst_q;
    skid_pc_d   = skid_pc_q;
    skid_inst_d = skid_inst_q;
    if (flush) begin
      state_d     = StEmpty;
      main_pc_d   = '0;
      main_inst_d = NOP_INST;
    end else begin
      unique case (state_q)
        StEmpty: begin
          if (acc_in) begin
            state_d     = StBusy;
            main_pc_d   = in_pc;
            main_inst_d = in_inst;
          end
        end
        StBusy: begin
          if (acc_in && acc_out) begin
            main_pc_d   = in_pc;
            main_inst_d = in_inst;
          end else if (acc_in) begin
            state_d     = StFull;
            skid_pc_d   = in_pc;
            skid_inst_d = in_inst;
          end else if (acc_out) begin
            state_d     = StEmpty;
            main_pc_d   = '0;
            main_inst_d = NOP_INST;
          end
        end
        StFull: begin
          if (acc_out) begin
            state_d     = StBusy;
            main_pc_d   = skid_pc_q;
            main_inst_d = skid_inst_q;
          end
        end
        default: begin
          state_d     = StEmpty;
          main_pc_d   = '0;
          main_inst_d = NOP_INST;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StEmpty;
      main_pc_q   <= '0;
      main_inst_q <= NOP_INST;
      skid_pc_q   <= '0;
      skid_inst_q <= NOP_INST;
    end else begin
      state_q     <= state_d;
      main_pc_q   <= main_pc_d;
      main_inst_q <= main_inst_d;
      skid_pc_q   <= skid_pc_d;
      skid_inst_q <= skid_inst_d;
    end
  end

`ifdef PERF_CNT_EN
  logic [CNT_W-1:0] stall_q, kills_q;
  logic [1:0]       kill_n;
  logic [CNT_W:0]   kills_sum;

  // A head delivered in the flush cycle is not a kill; an entry accepted in it is.
  always_comb begin
    kill_n    = {1'b0, main_valid & ~acc_out} + {1'b0, skid_valid} + {1'b0, acc_in};
    kills_sum = {1'b0, kills_q} + (CNT_W+1)'(kill_n);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_q <= '0;
      kills_q <= '0;
    end else begin
      if (main_valid && !out_ready && (stall_q != '1)) begin
        stall_q <= stall_q + 1'b1;
      end
      if (flush) begin
        kills_q <= kills_sum[CNT_W] ? '1 : kills_sum[CNT_W-1:0];
      end
    end
  end

  assign stall_cycles = stall_q;
  assign flush_kills  = kills_q;
`endif

endmodule
